// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryption controller: owns state/round-key registers, round count and Rcon,
// and time-shares one external combinational round datapath over NR rounds.
//
// state | meaning
// IDLE  | waiting for plaintext/key, in_ready high
// RUN   | one round per cycle through the external datapath
// DONE  | ciphertext held on out_data until out_ready
module aes_round_sequencer #(
   parameter int NR  = 10,
   parameter int RCW = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [127:0]     in_data,
   input  logic [127:0]     in_key,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     out_data,
   output logic [127:0]     rd_state,
   output logic [127:0]     rd_key,
   output logic [RCW-1:0]   rd_rcon,
   output logic             rd_last,
   input  logic [127:0]     rd_next_state,
   input  logic [127:0]     rd_next_key,
   output logic             busy,
   output logic [3:0]       round
);

   localparam logic [3:0] NR_L = 4'(NR);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } fsm_t;

   fsm_t         fsm;
   logic [127:0] state_reg;
   logic [127:0] key_reg;
   logic [7:0]   rcon_byte;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm       <= S_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         round     <= 4'd0;
         out_data  <= '0;
         state_reg <= '0;
         key_reg   <= '0;
      end else begin
         case (fsm)
            S_IDLE: begin
               if (in_valid && in_ready) begin
                  state_reg <= in_data ^ in_key;
                  key_reg   <= in_key;
                  round     <= 4'd1;
                  in_ready  <= 1'b0;
                  busy      <= 1'b1;
                  fsm       <= S_RUN;
               end
            end
            S_RUN: begin
               state_reg <= rd_next_state;
               key_reg   <= rd_next_key;
               // >= keeps the counter bounded even if it were ever corrupted past NR
               if (round >= NR_L) begin
                  out_data  <= rd_next_state;
                  out_valid <= 1'b1;
                  round     <= 4'd0;
                  busy      <= 1'b0;
                  fsm       <= S_DONE;
               end else begin
                  round <= round + 4'd1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  fsm       <= S_IDLE;
               end
            end
            default: begin
               fsm       <= S_IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               round     <= 4'd0;
               out_data  <= '0;
               state_reg <= '0;
               key_reg   <= '0;
            end
         endcase
      end
   end

   // Decoded from registers only, so the datapath sees stable controls for the whole cycle
   always_comb begin
      rcon_byte = 8'h00;
      if (fsm == S_RUN) begin
         case (round)
            4'd1:    rcon_byte = 8'h01;
            4'd2:    rcon_byte = 8'h02;
            4'd3:    rcon_byte = 8'h04;
            4'd4:    rcon_byte = 8'h08;
            4'd5:    rcon_byte = 8'h10;
            4'd6:    rcon_byte = 8'h20;
            4'd7:    rcon_byte = 8'h40;
            4'd8:    rcon_byte = 8'h80;
            4'd9:    rcon_byte = 8'h1b;
            4'd10:   rcon_byte = 8'h36;
            default: rcon_byte = 8'h00;
         endcase
      end
   end

   assign rd_rcon  = {rcon_byte, {(RCW-8){1'b0}}};
   assign rd_last  = (fsm == S_RUN) && (round == NR_L);
   assign rd_state = state_reg;
   assign rd_key   = key_reg;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: supplies a behavioural AES round datapath and checks the
// sequencer every cycle against a round-level model, plus FIPS-197 literal vectors.
module tb_aes_round_sequencer;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [127:0] in_data = '0;
   logic [127:0] in_key = '0;
   logic         in_ready, out_valid, rd_last, busy;
   logic [127:0] out_data, rd_state, rd_key, rd_next_state, rd_next_key;
   logic [31:0]  rd_rcon;
   logic [3:0]   round;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;

   always #5 clk = ~clk;

   aes_round_sequencer #(.NR(10), .RCW(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .rd_state(rd_state), .rd_key(rd_key), .rd_rcon(rd_rcon), .rd_last(rd_last),
      .rd_next_state(rd_next_state), .rd_next_key(rd_next_key),
      .busy(busy), .round(round)
   );

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = xt(x);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return 8'((b << n) | (b >> (8 - n)));
   endfunction

   // S-box from its definition: GF(2^8) inverse (x^254) followed by the affine map
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] r, e;
      r = 8'h01; e = 8'd254;
      for (int i = 7; i >= 0; i--) begin
         r = gmul(r, r);
         if (e[i]) r = gmul(r, x);
      end
      return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
   endfunction

   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
      return o;
   endfunction

   function automatic logic [127:0] mix(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0] a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
         o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                              a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                              a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                              xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
      end
      return o;
   endfunction

   function automatic logic [127:0] round_fn(input logic [127:0] s, input logic last);
      logic [127:0] t;
      t = sub_shift(s);
      return last ? t : mix(t);
   endfunction

   function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w3, t, n0, n1, n2, n3;
      w3 = k[31:0];
      t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
      n0 = k[127:96] ^ t;
      n1 = k[95:64] ^ n0;
      n2 = k[63:32] ^ n1;
      n3 = k[31:0] ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   function automatic logic [7:0] rcon_of(input int r);
      logic [7:0] rc;
      rc = 8'h01;
      for (int i = 1; i < r; i++) rc = xt(rc);
      return rc;
   endfunction

   function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
      logic [127:0] s, k;
      s = pt ^ key; k = key;
      for (int r = 1; r <= 10; r++) begin
         k = key_expand(k, rcon_of(r));
         s = round_fn(s, r == 10) ^ k;
      end
      return s;
   endfunction

   // External datapath as the sequencer expects it
   assign rd_next_key   = key_expand(rd_key, rd_rcon[31:24]);
   assign rd_next_state = round_fn(rd_state, rd_last) ^ rd_next_key;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Round-level model: round 0 with no pending result means idle
   int           m_round = 0;
   bit           m_pending = 1'b0;
   logic [127:0] m_state = '0, m_key = '0, m_result = '0, nk, ns;
   logic [127:0] exp_q[$];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_round = 0; m_pending = 1'b0; m_state = '0; m_key = '0;
         exp_q.delete();
      end else begin
         cyc++;
         if (m_pending) begin
            if (out_ready) m_pending = 1'b0;
         end else if (m_round > 0) begin
            nk = key_expand(m_key, rcon_of(m_round));
            ns = round_fn(m_state, m_round == 10) ^ nk;
            m_state = ns; m_key = nk;
            if (m_round == 10) begin
               m_result = ns; m_pending = 1'b1; m_round = 0;
            end else begin
               m_round++;
            end
         end else if (in_valid) begin
            m_state = in_data ^ in_key; m_key = in_key; m_round = 1;
            exp_q.push_back(aes_ref(in_data, in_key));
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("in_ready", 128'(in_ready), 128'(m_round == 0 && !m_pending));
         chk("busy", 128'(busy), 128'(m_round > 0));
         chk("out_valid", 128'(out_valid), 128'(m_pending));
         chk("round", 128'(round), 128'(m_round));
         chk("rd_rcon", 128'(rd_rcon), 128'(m_round > 0 ? {rcon_of(m_round), 24'h0} : 32'h0));
         chk("rd_last", 128'(rd_last), 128'(m_round == 10));
         if (m_round > 0) begin
            chk("rd_state", rd_state, m_state);
            chk("rd_key", rd_key, m_key);
         end
         if (m_pending) chk("out_data_hold", out_data, m_result);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_handshake", 128'(1), 128'(0));
            else chk("out_vs_ref", out_data, exp_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [127:0] pt, input logic [127:0] k, output int t);
      in_valid = 1'b1; in_data = pt; in_key = k; t = -1;
      for (int i = 0; i < 40; i++) begin
         if (in_ready) begin
            step();
            t = cyc;
            break;
         end
         step();
      end
      if (t < 0) chk("send_timeout", 128'(0), 128'(1));
   endtask

   task automatic wait_ov(output int t, output logic [127:0] d);
      t = -1; d = '0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) begin
            t = cyc; d = out_data;
            break;
         end
         step();
      end
      if (t < 0) chk("out_valid_timeout", 128'(0), 128'(1));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
      chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
      chk({tag, "_busy"}, 128'(busy), 128'(0));
      chk({tag, "_round"}, 128'(round), 128'(0));
      chk({tag, "_out_data"}, out_data, 128'(0));
      chk({tag, "_rd_rcon"}, 128'(rd_rcon), 128'(0));
      chk({tag, "_rd_last"}, 128'(rd_last), 128'(0));
      chk({tag, "_rd_state"}, rd_state, 128'(0));
      chk({tag, "_rd_key"}, rd_key, 128'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int ta, t1, t2;
      logic [127:0] d1, d2;

      repeat (3) @(posedge clk);
      #2;
      chk_reset_vals("reset");
      rst = 1'b0;
      step();

      // FIPS-197 C.1 with out_ready high
      out_ready = 1'b1;
      send(C1_PT, C1_KEY, ta);
      in_valid = 1'b0;
      wait_ov(t1, d1);
      chk("c1_latency", 128'(t1 - ta), 128'(10));
      chk("c1_out", d1, C1_CT);
      step(); step();

      // App.B with input drop during RUN, then backpressure in DONE
      out_ready = 1'b0;
      send(B_PT, B_KEY, ta);
      in_valid = 1'b0;
      in_data = {$urandom, $urandom, $urandom, $urandom};
      in_key  = {$urandom, $urandom, $urandom, $urandom};
      step();
      chk("appb_round1_key", rd_key, B_RK1);
      wait_ov(t1, d1);
      chk("appb_latency", 128'(t1 - ta), 128'(10));
      chk("appb_out", d1, B_CT);
      in_valid = 1'b1;
      in_data = {$urandom, $urandom, $urandom, $urandom};
      repeat (20) begin
         step();
         chk("bp_valid", 128'(out_valid), 128'(1));
         chk("bp_data", out_data, B_CT);
         chk("bp_in_ready", 128'(in_ready), 128'(0));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      chk("bp_post_valid", 128'(out_valid), 128'(0));
      chk("bp_post_in_ready", 128'(in_ready), 128'(1));
      step();

      // Back-to-back with in_valid held high
      send(C1_PT, C1_KEY, ta);
      in_data = B_PT; in_key = B_KEY;
      wait_ov(t1, d1);
      step();
      wait_ov(t2, d2);
      in_valid = 1'b0;
      chk("b2b_first", d1, C1_CT);
      chk("b2b_second", d2, B_CT);
      chk("b2b_spacing", 128'(t2 - t1), 128'(12));
      step(); step();

      // Asynchronous reset at round 5
      send(C1_PT, C1_KEY, ta);
      in_valid = 1'b0;
      repeat (4) step();
      chk("pre_reset_round", 128'(round), 128'(5));
      rst = 1'b1;
      #1;
      chk_reset_vals("mid_run_reset");
      step();
      rst = 1'b0;
      step();
      send(C1_PT, C1_KEY, ta);
      in_valid = 1'b0;
      wait_ov(t1, d1);
      chk("post_reset_latency", 128'(t1 - ta), 128'(10));
      chk("post_reset_out", d1, C1_CT);

      // Random traffic against the model
      repeat (400) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = {$urandom, $urandom, $urandom, $urandom};
         in_key    = {$urandom, $urandom, $urandom, $urandom};
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (30) step();
      chk("drain_all_results", 128'(exp_q.size()), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
